d_cell_unit: RTL and testbench
==============================

// Module: d_cell_unit
// PURPOSE
//  CPU-side initiator for the data-memory bus (d_req/d_dir/d_addr/d_wdata/d_ack/d_rdata).
//  Turns single cell commands (INC, DEC, LOAD, STORE) into bus reads and writes;
//  INC/DEC are read-modify-write sequences.
//  Sits between the bfcpu execute stage and the data memory; it is the only master on that bus.
// PARAMETERS
//  d_addr_width  8'd8  width of cmd_addr / d_addr
// PORTS
//  clk        in   1             single clock, all logic on posedge
//  rst        in   1             synchronous, active-high reset
//  cmd_valid  in   1             command offered
//  cmd_ready  out  1             unit can accept; high only in IDLE
//  cmd_op     in   2             OP_INC=0, OP_DEC=1, OP_LOAD=2, OP_STORE=3
//  cmd_addr   in   d_addr_width  cell address
//  cmd_data   in   8             store data (OP_STORE only)
//  rsp_valid  out  1             one-cycle pulse: command complete
//  rsp_data   out  8             resulting cell value (new value for INC/DEC/STORE, read value for LOAD)
//  rsp_zero   out  1             rsp_data == 8'h00 (drives loop branches)
//  d_req      out  1             bus request
//  d_dir      out  1             `DIRECTION_READ / `DIRECTION_WRITE (macros/direction.vh)
//  d_addr     out  d_addr_width  bus address
//  d_wdata    out  8             bus write data
//  d_ack      in   1             bus acknowledge; d_rdata is valid while d_ack=1 on a read
//  d_rdata    in   8             bus read data
// BEHAVIOUR
//  Reset: the FSM enters IDLE. d_req, rsp_valid and rsp_zero are 0; d_dir is READ.
//   d_addr, d_wdata and rsp_data are 0. cmd_ready goes to 1 on the first cycle after reset.
//  Accept: the command is accepted on an edge where cmd_valid && cmd_ready.
//   op, addr and data are latched; later changes on the cmd_* inputs are ignored.
//  Bus rules:
//   - d_req, d_dir, d_addr and d_wdata are registered.
//   - They are held stable from d_req rise until the cycle d_ack=1 is seen.
//   - d_req drops on the edge following the ack.
//   - d_req is low for at least one cycle between transactions, because the responder holds ack while req stays high.
//   - d_ack seen while d_req=0 is ignored.
//  FSM states: IDLE, RD, GAP, WR, DONE.
//   IDLE -> RD    on accepted INC/DEC/LOAD (cache miss)
//   IDLE -> WR    on accepted STORE, or INC/DEC cache hit
//   RD   -> GAP   on d_ack if INC/DEC. Capture d_rdata, compute d_wdata = rdata +/- 1 (8-bit wrap).
//   RD   -> DONE  on d_ack if LOAD. Capture d_rdata.
//   GAP  -> WR    unconditionally; d_req=0 for this cycle
//   WR   -> DONE  on d_ack
//   DONE -> IDLE  unconditionally; rsp_valid=1 and d_req=0 for this cycle
//  Latency against a one-cycle-ack responder:
//   LOAD/STORE: rsp_valid in cycle 3 after accept; INC/DEC (miss): cycle 6; INC/DEC (hit): cycle 3.
//  Arithmetic: 8'hFF+1 = 8'h00; 8'h00-1 = 8'hFF.
//   rsp_zero is registered together with rsp_data. rsp_data and rsp_zero hold until the next DONE.
//  A stalled bus (no ack) keeps the unit in RD or WR indefinitely; there is no timeout.
//  Reset mid-operation:
//   - The command is dropped with no rsp_valid; d_req=0 from the reset edge.
//   - A write already in progress may or may not have been committed.
//   - The cache is invalidated.
// CONFIGURATION
//  D_CELL_CACHE_EN defined:
//   - The unit keeps one cached entry (valid, addr, value).
//   - The entry is updated at every RD ack and every WR ack; reset clears valid.
//   - INC/DEC hit (valid && addr match): skip RD/GAP, go straight to WR with value +/- 1.
//   - LOAD hit: IDLE -> DONE with the cached value and no bus traffic (rsp_valid in cycle 2).
//   - STORE is unaffected apart from the cache update.
//   - Correct only because this unit is the sole bus master.
//  Not defined: no cache registers; every INC/DEC/LOAD performs RD.
// STRUCTURE
//  - Shared header macros/d_cell_op.vh: OP_INC, OP_DEC, OP_LOAD, OP_STORE and the FSM state encodings.
//  - Direction codes come from the existing macros/direction.vh.
//  - No sub-module: the +/-1 logic and the single-entry cache are a few inline registers.
// TESTING (bench pairs the unit with the existing one-cycle-ack data memory, 64 cells)
//  - STORE addr 5 data 8'h41, then LOAD addr 5 -> rsp_data=8'h41, rsp_zero=0; STORE rsp in cycle 3.
//  - Cell 7 = 8'hFF, INC addr 7 -> rsp_data=8'h00, rsp_zero=1, memory[7]=8'h00; RD ack, GAP with d_req=0, WR.
//  - Cell 3 = 8'h00, DEC addr 3 -> 8'hFF; check d_req never high two cycles past an ack.
//  - cmd_valid held high with 4 back-to-back INCs to addr 9 from 8'h10 -> 8'h14.
//    cmd_ready is 0 outside IDLE; no command is lost or duplicated.
//    With D_CELL_CACHE_EN, the 2nd to 4th INCs issue no read.
//  - Assert rst while in WR -> next cycle d_req=0, cmd_ready=1, no rsp_valid.
//    A following LOAD reads memory, not the stale cache.
//  - Responder delays ack 5 cycles -> d_addr/d_dir/d_wdata remain stable and the result is still correct.

Source files
------------

// File: rtl/d_cell_unit_pkg.sv
// Shared constants for the data-cell bus initiator: command opcodes,
// FSM state encodings and bus direction codes.
package d_cell_unit_pkg;

    localparam logic [1:0] OP_INC   = 2'd0;
    localparam logic [1:0] OP_DEC   = 2'd1;
    localparam logic [1:0] OP_LOAD  = 2'd2;
    localparam logic [1:0] OP_STORE = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_GAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/d_cell_unit.sv
// Data-memory bus initiator: runs INC/DEC (read-modify-write), LOAD and STORE cell commands.
// Optional feature: define D_CELL_CACHE_EN for a single-entry cell cache.
module d_cell_unit
    import d_cell_unit_pkg::*;
#(
    parameter int d_addr_width = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [d_addr_width-1:0] cmd_addr,
    input  logic [7:0]              cmd_data,
    output logic                    rsp_valid,
    output logic [7:0]              rsp_data,
    output logic                    rsp_zero,
    output logic                    d_req,
    output logic                    d_dir,
    output logic [d_addr_width-1:0] d_addr,
    output logic [7:0]              d_wdata,
    input  logic                    d_ack,
    input  logic [7:0]              d_rdata
);

    function automatic logic [7:0] step_cell(input logic [1:0] op, input logic [7:0] v);
        return (op == OP_DEC) ? v - 8'd1 : v + 8'd1;
    endfunction

    function automatic logic is_zero(input logic [7:0] v);
        return v == 8'h00;
    endfunction

    logic [2:0] state;
    logic [1:0] op_q;
    logic       accept;

`ifdef D_CELL_CACHE_EN
    logic                    c_vld;
    logic [d_addr_width-1:0] c_addr;
    logic [7:0]              c_val;
    logic                    lkp;
    logic                    c_hit;

    // A LOAD hit spends one cycle in IDLE with lkp set before answering.
    assign c_hit     = c_vld && (c_addr == cmd_addr);
    assign cmd_ready = (state == S_IDLE) && !lkp;
`else
    assign cmd_ready = (state == S_IDLE);
`endif

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            d_req     <= 1'b0;
            d_dir     <= DIR_READ;
            d_addr    <= '0;
            d_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
`ifdef D_CELL_CACHE_EN
            c_vld     <= 1'b0;
            lkp       <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef D_CELL_CACHE_EN
                    if (lkp) begin
                        lkp       <= 1'b0;
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= c_val;
                        rsp_zero  <= is_zero(c_val);
                    end else
`endif
                    if (accept) begin
                        op_q   <= cmd_op;
                        d_addr <= cmd_addr;
                        if (cmd_op == OP_STORE) begin
                            state   <= S_WR;
                            d_req   <= 1'b1;
                            d_dir   <= DIR_WRITE;
                            d_wdata <= cmd_data;
                        end
`ifdef D_CELL_CACHE_EN
                        else if (c_hit && (cmd_op == OP_LOAD)) begin
                            lkp <= 1'b1;
                        end else if (c_hit) begin
                            state   <= S_WR;
                            d_req   <= 1'b1;
                            d_dir   <= DIR_WRITE;
                            d_wdata <= step_cell(cmd_op, c_val);
                        end
`endif
                        else begin
                            state <= S_RD;
                            d_req <= 1'b1;
                            d_dir <= DIR_READ;
                        end
                    end
                end

                S_RD: begin
                    if (d_ack) begin
                        d_req <= 1'b0;
`ifdef D_CELL_CACHE_EN
                        c_vld  <= 1'b1;
                        c_addr <= d_addr;
                        c_val  <= d_rdata;
`endif
                        if (op_q == OP_LOAD) begin
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= d_rdata;
                            rsp_zero  <= is_zero(d_rdata);
                        end else begin
                            state   <= S_GAP;
                            d_wdata <= step_cell(op_q, d_rdata);
                        end
                    end
                end

                // Responder keeps ack high while req is high, so req idles one cycle here.
                S_GAP: begin
                    state <= S_WR;
                    d_req <= 1'b1;
                    d_dir <= DIR_WRITE;
                end

                S_WR: begin
                    if (d_ack) begin
                        d_req     <= 1'b0;
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= d_wdata;
                        rsp_zero  <= is_zero(d_wdata);
`ifdef D_CELL_CACHE_EN
                        c_vld  <= 1'b1;
                        c_addr <= d_addr;
                        c_val  <= d_wdata;
`endif
                    end
                end

                S_DONE: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_d_cell_unit.sv
// Bench for d_cell_unit: 64-cell memory responder with programmable ack delay,
// cell-semantics reference model and a bus-protocol monitor.
module tb_d_cell_unit;
    import d_cell_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_addr = 8'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_zero;
    logic       d_req;
    logic       d_dir;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_ack = 1'b0;
    logic [7:0] d_rdata = 8'd0;

    d_cell_unit #(.d_addr_width(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
        .d_req(d_req), .d_dir(d_dir), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory responder: ack after ack_delay extra cycles, held while req stays high.
    logic [7:0] mem [64];
    int         ack_delay = 0;
    int         ack_cnt = 0;
    logic       mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 37 + 5);
            d_ack   <= 1'b0;
            ack_cnt <= 0;
        end else if (!d_req) begin
            d_ack   <= 1'b0;
            ack_cnt <= 0;
        end else if (!d_ack) begin
            if (ack_cnt >= ack_delay) begin
                d_ack <= 1'b1;
                if (d_dir == DIR_WRITE) mem[d_addr[5:0]] <= d_wdata;
                else                    d_rdata <= mem[d_addr[5:0]];
            end else begin
                ack_cnt <= ack_cnt + 1;
            end
        end
    end

    // Protocol monitor: req drops right after an ack, fields stable while waiting, ready only idle.
    logic       p_req = 1'b0, p_ack = 1'b0, p_dir = 1'b0;
    logic [7:0] p_addr = 8'd0, p_wdata = 8'd0;
    int         proto_err = 0;

    always @(posedge clk) begin
        p_req   <= d_req;
        p_ack   <= d_ack;
        p_dir   <= d_dir;
        p_addr  <= d_addr;
        p_wdata <= d_wdata;
        if (!rst) begin
            proto_err <= proto_err
                + int'(p_req && p_ack && d_req)
                + int'(p_req && !p_ack && d_req &&
                       (d_addr != p_addr || d_dir != p_dir || d_wdata != p_wdata))
                + int'(cmd_ready && d_req);
        end
    end

    // Reference model: cell contents and, when the cache is built in, the cached address.
    logic [7:0] ref_mem [64];
    bit         cm_vld = 1'b0;
    logic [7:0] cm_addr = 8'd0;

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                          output logic [7:0] rd, output logic rz, output int lat, output bit ok);
        int w;
        rd = 8'd0; rz = 1'b0; lat = 0; ok = 1'b0; w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 8'($urandom);
        cmd_data  = 8'($urandom);
        for (int i = 1; i < 300; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = i; rd = rsp_data; rz = rsp_zero; ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] data,
                          input string tag);
        logic [7:0] rd, exp_v;
        logic       rz;
        int         lat, exp_lat, d;
        bit         ok, hit, rmw;
        d   = ack_delay;
        hit = 1'b0;
`ifdef D_CELL_CACHE_EN
        hit = cm_vld && (cm_addr == addr);
`endif
        rmw = (op == OP_INC) || (op == OP_DEC);
        case (op)
            OP_INC:  exp_v = ref_mem[addr[5:0]] + 8'd1;
            OP_DEC:  exp_v = ref_mem[addr[5:0]] - 8'd1;
            OP_LOAD: exp_v = ref_mem[addr[5:0]];
            default: exp_v = data;
        endcase
        if (op == OP_LOAD && hit) exp_lat = 2;
        else if (rmw && !hit)     exp_lat = 6 + 2 * d;
        else                      exp_lat = 3 + d;
        do_cmd(op, addr, data, rd, rz, lat, ok);
        chk({tag, ".done"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({tag, ".data"}, 32'(rd), 32'(exp_v));
            chk({tag, ".zero"}, 32'(rz), 32'(exp_v == 8'h00));
            chk({tag, ".lat"},  32'(lat), 32'(exp_lat));
        end
        ref_mem[addr[5:0]] = exp_v;
        chk({tag, ".mem"}, 32'(mem[addr[5:0]]), 32'(exp_v));
        cm_vld = 1'b1; cm_addr = addr;
    endtask

    initial begin
        int accepts, resps, w;
        logic [7:0] exp_b2b;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int accepts, resps, w, stray;
        logic [7:0] exp_b2b;
        repeat (3) @(negedge clk);
        mem_init = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst.d_req",     32'(d_req),     32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp_zero",  32'(rsp_zero),  32'd0);
        chk("rst.d_dir",     32'(d_dir),     32'(DIR_READ));
        chk("rst.d_addr",    32'(d_addr),    32'd0);
        chk("rst.d_wdata",   32'(d_wdata),   32'd0);
        chk("rst.rsp_data",  32'(rsp_data),  32'd0);
        chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);

        run_op(OP_STORE, 8'd5, 8'h41, "store5");
        run_op(OP_LOAD,  8'd5, 8'h00, "load5");
        run_op(OP_STORE, 8'd7, 8'hFF, "store7");
        run_op(OP_INC,   8'd7, 8'h00, "inc7wrap");
        run_op(OP_STORE, 8'd3, 8'h00, "store3");
        run_op(OP_DEC,   8'd3, 8'h00, "dec3wrap");
        run_op(OP_LOAD,  8'd20, 8'h00, "load20");

        // Four INCs to cell 9 with cmd_valid held high throughout.
        run_op(OP_STORE, 8'd9, 8'h10, "store9");
        accepts = 0; resps = 0; exp_b2b = 8'h10;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_INC; cmd_addr = 8'd9; cmd_data = 8'hAA;
        for (int i = 0; i < 300 && resps < 4; i++) begin
            if (rsp_valid) begin
                resps++;
                exp_b2b = exp_b2b + 8'd1;
                chk("b2b.rsp", 32'(rsp_data), 32'(exp_b2b));
            end
            if (accepts == 4) cmd_valid = 1'b0;
            else if (cmd_ready) accepts++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) resps++;
        end
        chk("b2b.accepts", 32'(accepts), 32'd4);
        chk("b2b.resps",   32'(resps),   32'd4);
        chk("b2b.mem",     32'(mem[9]),  32'h14);
        ref_mem[9] = 8'h14; cm_vld = 1'b1; cm_addr = 8'd9;

        // Slow responder: five-cycle ack delay.
        ack_delay = 5;
        run_op(OP_INC,  8'd9,  8'h00, "slow.inc9");
        run_op(OP_LOAD, 8'd33, 8'h00, "slow.load33");
        run_op(OP_DEC,  8'd33, 8'h00, "slow.dec33");

        // Reset asserted while a STORE is waiting in WR.
        run_op(OP_LOAD, 8'd12, 8'h00, "pre.load12");
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd_op = OP_STORE; cmd_addr = 8'd12; cmd_data = 8'h5A;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        w = 0;
        @(negedge clk);
        while (!(d_req && d_dir == DIR_WRITE) && w < 50) begin @(negedge clk); w++; end
        chk("rstwr.in_wr", 32'(d_req && d_dir == DIR_WRITE), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstwr.d_req",     32'(d_req),     32'd0);
        chk("rstwr.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstwr.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) stray++;
        end
        chk("rstwr.no_rsp", 32'(stray), 32'd0);
        ref_mem[12] = mem[12];
        cm_vld = 1'b0;
        ack_delay = 0;
        run_op(OP_LOAD, 8'd12, 8'h00, "post.load12");

        // Randomized commands against the reference model.
        for (int k = 0; k < 40; k++) begin
            ack_delay = int'($urandom_range(0, 3));
            run_op(2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 8'($urandom), "rand");
        end

        repeat (3) @(negedge clk);
        chk("proto", 32'(proto_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
